// File: rtl/dcache_bank_arbiter_if.sv
// Bundles the request, grant, bank-array and load-return signals of the DCache data bank arbiter.
// slave: the arbiter's view. master: the requesters' and bank array's view (used by the bench).
// Ports: refill_*, store_*, load_* request/grant groups; bank_* array drive; load_r* return path.
interface dcache_bank_arbiter_if #(
    parameter int LOAD_PORTS = 2,
    parameter int BANKS      = 4,
    parameter int WAYS       = 4,
    parameter int SET_WIDTH  = 6,
    parameter int BITS       = 32
);
    localparam int BYTES  = BITS / 8;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic                                refill_valid;
    logic [WAYS-1:0]                     refill_way;
    logic [SET_WIDTH-1:0]                refill_index;
    logic [BANKS*BITS-1:0]               refill_data;
    logic                                refill_ready;

    logic                                store_valid;
    logic [BANK_W-1:0]                   store_bank;
    logic [SET_WIDTH-1:0]                store_index;
    logic [WAYS-1:0]                     store_way;
    logic [BYTES-1:0]                    store_mask;
    logic [BITS-1:0]                     store_data;
    logic                                store_ready;

    logic [LOAD_PORTS-1:0]               load_valid;
    logic [LOAD_PORTS*BANK_W-1:0]        load_bank;
    logic [LOAD_PORTS*SET_WIDTH-1:0]     load_index;
    logic [LOAD_PORTS-1:0]               load_grant;
    logic [LOAD_PORTS-1:0]               load_conflict;

    logic [BANKS-1:0]                    bank_en;
    logic [BANKS*WAYS*BYTES-1:0]         bank_we;
    logic [BANKS*SET_WIDTH-1:0]          bank_index;
    logic [BANKS*BITS-1:0]               bank_wdata;
    logic [BANKS*WAYS*BITS-1:0]          bank_rdata;

    logic [LOAD_PORTS-1:0]               load_rvalid;
    logic [LOAD_PORTS*WAYS*BITS-1:0]     load_rdata;

    modport slave (
        input  refill_valid, refill_way, refill_index, refill_data,
        output refill_ready,
        input  store_valid, store_bank, store_index, store_way, store_mask, store_data,
        output store_ready,
        input  load_valid, load_bank, load_index,
        output load_grant, load_conflict,
        output bank_en, bank_we, bank_index, bank_wdata,
        input  bank_rdata,
        output load_rvalid, load_rdata
    );

    modport master (
        output refill_valid, refill_way, refill_index, refill_data,
        input  refill_ready,
        output store_valid, store_bank, store_index, store_way, store_mask, store_data,
        input  store_ready,
        output load_valid, load_bank, load_index,
        input  load_grant, load_conflict,
        input  bank_en, bank_we, bank_index, bank_wdata,
        output bank_rdata,
        input  load_rvalid, load_rdata
    );
endinterface

// File: rtl/dcache_bank_arbiter.sv
// Per-cycle arbiter for the single-port DCache data banks: refill > store > loads, with store anti-starvation.
// Latency: grants/bank drive combinational; load_rvalid registered, load_rdata follows the bank's 1-cycle read.
// Backpressure: nothing is queued; losers see ready=0 / load_conflict=1 and must hold or replay.
// Ports: clk, rst (async active-high), bus (dcache_bank_arbiter_if.slave).
module dcache_bank_arbiter #(
    parameter int LOAD_PORTS   = 2,
    parameter int BANKS        = 4,
    parameter int WAYS         = 4,
    parameter int SET_WIDTH    = 6,
    parameter int BITS         = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    dcache_bank_arbiter_if.slave  bus
);
    localparam int BYTES  = BITS / 8;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int PTR_W  = (LOAD_PORTS > 1) ? $clog2(LOAD_PORTS) : 1;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int ROW_W  = WAYS * BITS;

    logic [PTR_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   starve_cnt;
    logic [LOAD_PORTS-1:0] rvalid_q;
    logic [BANK_W-1:0]  cap_bank [LOAD_PORTS];

    logic               store_force;
    logic               refill_gnt;
    logic               store_gnt;
    logic [LOAD_PORTS-1:0] load_gnt;
    logic               rr_upd;
    logic [PTR_W-1:0]   rr_next;

    logic [BANKS-1:0]              bank_en;
    logic [BANKS*WAYS*BYTES-1:0]   bank_we;
    logic [BANKS*SET_WIDTH-1:0]    bank_index;
    logic [BANKS*BITS-1:0]         bank_wdata;
    logic [LOAD_PORTS*ROW_W-1:0]   load_rdata;

    // A store that has lost STARVE_LIMIT cycles in a row beats the refill once.
    always_comb begin
        store_force = bus.store_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));
        refill_gnt  = bus.refill_valid && !store_force;
        store_gnt   = bus.store_valid && !refill_gnt;
    end

    // Loads are visited in round-robin order starting at rr_ptr. The first eligible
    // port to reach a bank claims it; later ports on that bank share the read if the
    // index matches, otherwise they lose. The first such loss moves rr_ptr past the owner.
    always_comb begin : load_arb
        logic                 claimed   [BANKS];
        logic [SET_WIDTH-1:0] claim_idx [BANKS];
        logic [PTR_W-1:0]     claim_port[BANKS];
        logic [BANK_W-1:0]    lb;
        logic [SET_WIDTH-1:0] li;
        logic                 blocked;
        int                   p;
        load_gnt = '0;
        rr_upd   = 1'b0;
        rr_next  = rr_ptr;
        lb       = '0;
        li       = '0;
        blocked  = 1'b0;
        p        = 0;
        for (int b = 0; b < BANKS; b++) begin
            claimed[b]    = 1'b0;
            claim_idx[b]  = '0;
            claim_port[b] = '0;
        end
        for (int k = 0; k < LOAD_PORTS; k++) begin
            p = int'(rr_ptr) + k;
            if (p >= LOAD_PORTS) p = p - LOAD_PORTS;
            lb      = bus.load_bank[p*BANK_W +: BANK_W];
            li      = bus.load_index[p*SET_WIDTH +: SET_WIDTH];
            blocked = refill_gnt || (store_gnt && (bus.store_bank == lb));
            if (bus.load_valid[p] && !blocked) begin
                if (!claimed[lb]) begin
                    claimed[lb]    = 1'b1;
                    claim_idx[lb]  = li;
                    claim_port[lb] = PTR_W'(p);
                    load_gnt[p]    = 1'b1;
                end else if (claim_idx[lb] == li) begin
                    load_gnt[p] = 1'b1;
                end else if (!rr_upd) begin
                    rr_upd = 1'b1;
                    if (int'(claim_port[lb]) == LOAD_PORTS - 1) rr_next = '0;
                    else                                        rr_next = claim_port[lb] + PTR_W'(1);
                end
            end
        end
    end

    // Bank drive: refill takes every bank; otherwise the store bank and any granted loads.
    always_comb begin
        bank_en    = '0;
        bank_we    = '0;
        bank_index = '0;
        bank_wdata = '0;
        if (refill_gnt) begin
            for (int b = 0; b < BANKS; b++) begin
                bank_en[b]                          = 1'b1;
                bank_index[b*SET_WIDTH +: SET_WIDTH] = bus.refill_index;
                bank_wdata[b*BITS +: BITS]          = bus.refill_data[b*BITS +: BITS];
                for (int w = 0; w < WAYS; w++)
                    bank_we[(b*WAYS+w)*BYTES +: BYTES] = {BYTES{bus.refill_way[w]}};
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                if (store_gnt && (bus.store_bank == BANK_W'(b))) begin
                    bank_en[b]                          = 1'b1;
                    bank_index[b*SET_WIDTH +: SET_WIDTH] = bus.store_index;
                    bank_wdata[b*BITS +: BITS]          = bus.store_data;
                    for (int w = 0; w < WAYS; w++)
                        bank_we[(b*WAYS+w)*BYTES +: BYTES] = bus.store_mask & {BYTES{bus.store_way[w]}};
                end
                for (int p = 0; p < LOAD_PORTS; p++) begin
                    if (load_gnt[p] && (bus.load_bank[p*BANK_W +: BANK_W] == BANK_W'(b))) begin
                        bank_en[b]                          = 1'b1;
                        bank_index[b*SET_WIDTH +: SET_WIDTH] = bus.load_index[p*SET_WIDTH +: SET_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            starve_cnt <= '0;
            rvalid_q   <= '0;
            for (int p = 0; p < LOAD_PORTS; p++) cap_bank[p] <= '0;
        end else begin
            if (rr_upd) rr_ptr <= rr_next;
            if (bus.store_valid && !store_gnt) begin
                if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);
            end else begin
                starve_cnt <= '0;
            end
            rvalid_q <= load_gnt;
            for (int p = 0; p < LOAD_PORTS; p++)
                if (load_gnt[p]) cap_bank[p] <= bus.load_bank[p*BANK_W +: BANK_W];
        end
    end

    // The banks register their own read data, so only the bank select is held here.
    always_comb begin
        load_rdata = '0;
        for (int p = 0; p < LOAD_PORTS; p++)
            load_rdata[p*ROW_W +: ROW_W] = bus.bank_rdata[int'(cap_bank[p])*ROW_W +: ROW_W];
    end

    assign bus.refill_ready  = refill_gnt;
    assign bus.store_ready   = store_gnt;
    assign bus.load_grant    = load_gnt;
    assign bus.load_conflict = bus.load_valid & ~load_gnt;
    assign bus.bank_en       = bank_en;
    assign bus.bank_we       = bank_we;
    assign bus.bank_index    = bank_index;
    assign bus.bank_wdata    = bank_wdata;
    assign bus.load_rvalid   = rvalid_q;
    assign bus.load_rdata    = load_rdata;
endmodule

// File: tb/tb_dcache_bank_arbiter.sv
module tb_dcache_bank_arbiter;
    localparam int LP = 2, BANKS = 4, WAYS = 4, SW = 6, BITS = 32, SL = 8;
    localparam logic [127:0] RDATA = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_bank_arbiter_if #(.LOAD_PORTS(LP), .BANKS(BANKS), .WAYS(WAYS), .SET_WIDTH(SW), .BITS(BITS)) bus ();

    dcache_bank_arbiter #(.LOAD_PORTS(LP), .BANKS(BANKS), .WAYS(WAYS), .SET_WIDTH(SW),
                          .BITS(BITS), .STARVE_LIMIT(SL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic         rv;    logic [3:0]  rway;  logic [5:0]  ridx;
        logic         sv;    logic [1:0]  sbank; logic [5:0]  sidx;
        logic [3:0]   sway;  logic [3:0]  smask; logic [31:0] sdata;
        logic [1:0]   lv;    logic [3:0]  lbank; logic [11:0] lidx;
        logic         e_rr;  logic        e_sr;
        logic [1:0]   e_gnt; logic [1:0]  e_cf;  logic [3:0]  e_en;
        logic [63:0]  e_we;  logic [23:0] e_idx; logic [127:0] e_wd;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rows(input int b);
        logic [127:0] r;
        for (int w = 0; w < WAYS; w++) r[w*BITS +: BITS] = 32'hD000_0000 | (b << 8) | w;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        bus.refill_valid = v.rv;  bus.refill_way = v.rway; bus.refill_index = v.ridx;
        bus.refill_data  = RDATA;
        bus.store_valid  = v.sv;  bus.store_bank = v.sbank; bus.store_index = v.sidx;
        bus.store_way    = v.sway; bus.store_mask = v.smask; bus.store_data = v.sdata;
        bus.load_valid   = v.lv;  bus.load_bank = v.lbank; bus.load_index = v.lidx;
    endtask

    task automatic set_req(input logic rv, input logic sv, input logic [1:0] lv,
                           input logic [3:0] lbank, input logic [11:0] lidx);
        bus.refill_valid = rv; bus.refill_way = 4'b0001; bus.refill_index = 6'd0;
        bus.refill_data  = RDATA;
        bus.store_valid  = sv; bus.store_bank = 2'd3; bus.store_index = 6'd0;
        bus.store_way    = 4'b0001; bus.store_mask = 4'hF; bus.store_data = 32'h0;
        bus.load_valid   = lv; bus.load_bank = lbank; bus.load_index = lidx;
    endtask

    initial begin
        logic [1:0] prev_gnt;
        logic [3:0] prev_bank;
        //          rv  rway     ridx   sv  sb    sidx   sway     smask  sdata          lv     lbank            lidx               rr  sr  gnt    cf     en       we                      idx           wd
        vt[0]  = '{1'b0, 4'b0000, 6'd0, 1'b0, 2'd0, 6'd0, 4'b0000, 4'h0, 32'h0,         2'b00, 4'h0,            12'h0,             1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 64'h0,                  24'h0,        128'h0};
        vt[1]  = '{1'b0, 4'b0000, 6'd0, 1'b0, 2'd0, 6'd0, 4'b0000, 4'h0, 32'h0,         2'b11, {2'd2, 2'd1},    {6'd7, 6'd3},      1'b0, 1'b0, 2'b11, 2'b00, 4'b0110, 64'h0,                  24'h0070C0,   128'h0};
        vt[2]  = '{1'b0, 4'b0000, 6'd0, 1'b0, 2'd0, 6'd0, 4'b0000, 4'h0, 32'h0,         2'b11, {2'd0, 2'd0},    {6'd9, 6'd5},      1'b0, 1'b0, 2'b01, 2'b10, 4'b0001, 64'h0,                  24'h000005,   128'h0};
        vt[3]  = '{1'b0, 4'b0000, 6'd0, 1'b0, 2'd0, 6'd0, 4'b0000, 4'h0, 32'h0,         2'b11, {2'd0, 2'd0},    {6'd9, 6'd5},      1'b0, 1'b0, 2'b10, 2'b01, 4'b0001, 64'h0,                  24'h000009,   128'h0};
        vt[4]  = '{1'b0, 4'b0000, 6'd0, 1'b0, 2'd0, 6'd0, 4'b0000, 4'h0, 32'h0,         2'b11, {2'd0, 2'd0},    {6'd9, 6'd5},      1'b0, 1'b0, 2'b01, 2'b10, 4'b0001, 64'h0,                  24'h000005,   128'h0};
        vt[5]  = '{1'b0, 4'b0000, 6'd0, 1'b0, 2'd0, 6'd0, 4'b0000, 4'h0, 32'h0,         2'b11, {2'd0, 2'd0},    {6'd9, 6'd5},      1'b0, 1'b0, 2'b10, 2'b01, 4'b0001, 64'h0,                  24'h000009,   128'h0};
        vt[6]  = '{1'b0, 4'b0000, 6'd0, 1'b0, 2'd0, 6'd0, 4'b0000, 4'h0, 32'h0,         2'b11, {2'd3, 2'd3},    {6'd2, 6'd2},      1'b0, 1'b0, 2'b11, 2'b00, 4'b1000, 64'h0,                  24'h080000,   128'h0};
        vt[7]  = '{1'b1, 4'b0100, 6'd4, 1'b1, 2'd1, 6'd2, 4'b0001, 4'hF, 32'h0,         2'b01, {2'd0, 2'd3},    {6'd0, 6'd1},      1'b1, 1'b0, 2'b00, 2'b01, 4'b1111, 64'h0F00_0F00_0F00_0F00, 24'h104104, RDATA};
        vt[8]  = '{1'b0, 4'b0000, 6'd0, 1'b1, 2'd2, 6'd6, 4'b0010, 4'h5, 32'h12345678,  2'b11, {2'd0, 2'd2},    {6'd3, 6'd1},      1'b0, 1'b1, 2'b10, 2'b01, 4'b0101, 64'h0000_0050_0000_0000, 24'h006003, 128'h0};
        vt[9]  = '{1'b0, 4'b0000, 6'd0, 1'b1, 2'd0, 6'd1, 4'b0001, 4'h0, 32'hCAFEF00D,  2'b00, 4'h0,            12'h0,             1'b0, 1'b1, 2'b00, 2'b00, 4'b0001, 64'h0,                  24'h000001,   {96'h0, 32'hCAFEF00D}};
        vt[10] = '{1'b0, 4'b0000, 6'd0, 1'b0, 2'd0, 6'd0, 4'b0000, 4'h0, 32'h0,         2'b00, 4'h0,            12'h0,             1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 64'h0,                  24'h0,        128'h0};

        for (int b = 0; b < BANKS; b++)
            for (int w = 0; w < WAYS; w++)
                bus.bank_rdata[(b*WAYS+w)*BITS +: BITS] = 32'hD000_0000 | (b << 8) | w;

        rst = 1'b1;
        drive(vt[0]);
        @(negedge clk);
        @(negedge clk);
        chk("reset rvalid", 256'(bus.load_rvalid), 256'(2'b00));
        chk("reset rr_ptr", 256'(dut.rr_ptr), 256'(0));
        chk("reset starve", 256'(dut.starve_cnt), 256'(0));
        chk("reset rdata bank0", 256'(bus.load_rdata), {rows(0), rows(0)});
        rst = 1'b0;
        @(negedge clk);

        prev_gnt  = 2'b00;
        prev_bank = 4'h0;
        for (int i = 0; i < 11; i++) begin
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d refill_ready", i), 256'(bus.refill_ready), 256'(vt[i].e_rr));
            chk($sformatf("v%0d store_ready", i), 256'(bus.store_ready), 256'(vt[i].e_sr));
            chk($sformatf("v%0d load_grant", i), 256'(bus.load_grant), 256'(vt[i].e_gnt));
            chk($sformatf("v%0d load_conflict", i), 256'(bus.load_conflict), 256'(vt[i].e_cf));
            chk($sformatf("v%0d bank_en", i), 256'(bus.bank_en), 256'(vt[i].e_en));
            chk($sformatf("v%0d bank_we", i), 256'(bus.bank_we), 256'(vt[i].e_we));
            chk($sformatf("v%0d bank_index", i), 256'(bus.bank_index), 256'(vt[i].e_idx));
            if (vt[i].rv || (vt[i].sv && vt[i].lv == 2'b00))
                chk($sformatf("v%0d bank_wdata", i), 256'(bus.bank_wdata), 256'(vt[i].e_wd));
            chk($sformatf("v%0d load_rvalid", i), 256'(bus.load_rvalid), 256'(prev_gnt));
            for (int p = 0; p < LP; p++)
                if (prev_gnt[p])
                    chk($sformatf("v%0d load_rdata%0d", i, p),
                        256'(bus.load_rdata[p*128 +: 128]), 256'(rows(int'(prev_bank[p*2 +: 2]))));
            prev_gnt  = vt[i].e_gnt;
            prev_bank = vt[i].lbank;
            @(negedge clk);
        end

        // Refill and store held together: refill wins SL cycles, then the store once.
        set_req(1'b1, 1'b1, 2'b00, 4'h0, 12'h0);
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk($sformatf("starve c%0d refill_ready", c), 256'(bus.refill_ready), 256'(c != 9));
            chk($sformatf("starve c%0d store_ready", c), 256'(bus.store_ready), 256'(c == 9));
            if (c == 9) chk("starve c9 bank_en", 256'(bus.bank_en), 256'(4'b1000));
            @(negedge clk);
            chk($sformatf("starve c%0d cnt", c), 256'(dut.starve_cnt),
                256'((c <= 8) ? c : (c == 9 ? 0 : 1)));
        end

        // Build up rr_ptr=1 and starve_cnt=5, then reset asynchronously mid-traffic.
        set_req(1'b0, 1'b0, 2'b11, {2'd0, 2'd0}, {6'd9, 6'd5});
        @(negedge clk);
        chk("pre-reset rr_ptr", 256'(dut.rr_ptr), 256'(1));
        set_req(1'b1, 1'b1, 2'b00, 4'h0, 12'h0);
        repeat (5) @(negedge clk);
        chk("pre-reset starve", 256'(dut.starve_cnt), 256'(5));
        set_req(1'b1, 1'b1, 2'b11, {2'd0, 2'd0}, {6'd9, 6'd5});
        rst = 1'b1;
        #1;
        chk("mid reset rr_ptr", 256'(dut.rr_ptr), 256'(0));
        chk("mid reset starve", 256'(dut.starve_cnt), 256'(0));
        chk("mid reset rvalid", 256'(bus.load_rvalid), 256'(2'b00));
        @(negedge clk);
        rst = 1'b0;
        set_req(1'b0, 1'b0, 2'b11, {2'd0, 2'd0}, {6'd9, 6'd5});
        #1;
        chk("post reset grant", 256'(bus.load_grant), 256'(2'b01));
        @(negedge clk);
        chk("post reset rvalid", 256'(bus.load_rvalid), 256'(2'b01));
        chk("post reset rdata0", 256'(bus.load_rdata[127:0]), 256'(rows(0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dcache_bank_arbiter.md
Name: dcache_bank_arbiter

Overview:
- Per-cycle arbiter and sequencer in front of the DCache data bank array.
- Shares the BANKS single-port data banks between a line refill writer, the committed-store writer and LOAD_PORTS load pipelines.
- Drives the banks' en/we/index/wdata signals.
- Routes each bank's registered read data back to the load port that won it, one cycle after the grant.

Parameters:
- LOAD_PORTS, 2, number of load pipelines.
- BANKS, 4, data banks per line.
- WAYS, 4, associativity.
- SET_WIDTH, 6, index width.
- BITS, 32, bank word width; BYTES = BITS/8.
- STARVE_LIMIT, 8, consecutive lost store cycles before the store overrides refill.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- refill_valid  in  1  line write request.
- refill_way  in  WAYS  one-hot victim way.
- refill_index  in  SET_WIDTH  set.
- refill_data  in  BANKS*BITS  full line, bank i at [i*BITS +: BITS].
- refill_ready  out  1  refill accepted this cycle.
- store_valid  in  1  store write request.
- store_bank  in  log2(BANKS)  target bank.
- store_index  in  SET_WIDTH  set.
- store_way  in  WAYS  one-hot hit way.
- store_mask  in  BYTES  byte enables.
- store_data  in  BITS  write data.
- store_ready  out  1  store accepted this cycle.
- load_valid  in  LOAD_PORTS  read requests.
- load_bank  in  LOAD_PORTS*log2(BANKS)  per-port bank.
- load_index  in  LOAD_PORTS*SET_WIDTH  per-port set.
- load_grant  out  LOAD_PORTS  read issued this cycle.
- load_conflict  out  LOAD_PORTS  valid but not granted; pipeline replays.
- bank_en  out  BANKS  bank enable.
- bank_we  out  BANKS*WAYS*BYTES  byte write enables, way-major.
- bank_index  out  BANKS*SET_WIDTH  bank address.
- bank_wdata  out  BANKS*BITS  bank write word (replicated per way by the array).
- bank_rdata  in  BANKS*WAYS*BITS  bank read data, valid one cycle after en.
- load_rvalid  out  LOAD_PORTS  read data valid (registered).
- load_rdata  out  LOAD_PORTS*WAYS*BITS  all-way data for the granted bank.

Behaviour:
- Reset (async, active-high): rr_ptr=0, starve_cnt=0, load_rvalid=0, captured bank selects=0.
- Grants, ready and bank_* outputs are combinational from the current inputs and state. load_rvalid and the load_rdata select are registered.
- Priority, normal case: refill > store > loads.
- Refill grant: refill_valid && !(store_valid && starve_cnt==STARVE_LIMIT). A refill owns all banks; no store or load is granted that cycle.
- Refill writes: every bank gets en=1, index=refill_index, wdata=refill_data slice, we = all BYTES bits set for each way in refill_way.
- Store grant: store_valid && no refill grant. Only store_bank is used.
- Store writes: en=1, index=store_index, we[w][b]=store_way[w]&store_mask[b].
- A store with an all-zero mask is still granted; en=1, we=0.
- Loads: a load is eligible if its bank is not used by a refill or store this cycle.
- Two eligible loads to the same bank and same index are both granted (shared read).
- Two eligible loads to the same bank with different index: the port at or after rr_ptr wins, the other gets load_conflict.
- After a resolved load conflict, rr_ptr moves to winner+1 mod LOAD_PORTS. Otherwise rr_ptr holds.
- load_conflict[p] = load_valid[p] && !load_grant[p]. Loads blocked by refill or store also raise conflict.
- Read data: load_rvalid[p] <= load_grant[p]; the granted bank number is captured.
- load_rdata[p] = bank_rdata slice of the captured bank, with no extra latency beyond the bank's 1 cycle.
- starve_cnt: increments, saturating at STARVE_LIMIT, when store_valid && !store_ready. Clears on store accept or when !store_valid.
- At STARVE_LIMIT the store overrides the refill and refill_ready=0. The refill retries next cycle.
- Idle banks: en=0, we=0. index and wdata are don't-care but driven to 0.
- No request is held internally; a requester holds valid until ready or grant.

Test Plan:
- Reset asserted mid-traffic with rr_ptr=1, starve_cnt=5 → next cycle load_rvalid=0, rr_ptr=0, starve_cnt=0.
- Load0 bank1 idx3 + load1 bank2 idx7, no writes → both granted. Next cycle load_rvalid=2'b11, load_rdata[0]=bank1 data, load_rdata[1]=bank2 data.
- Load0 and load1 both bank0, idx5 vs idx9, repeated 4 cycles with rr_ptr=0 → grant alternates 01,10,01,10; the loser has load_conflict=1 each cycle.
- Refill way2 idx4 + store bank1 + load bank3 → refill_ready=1, bank_en=4'hF, bank_we has only way2 bytes set in all banks, store_ready=0, load_conflict=1.
- Store bank2 way1 mask 4'b0101 + load bank2 + load bank0 → store_ready=1, bank_we[2]=way1 bytes 0,2 only, load on bank2 conflicts, load on bank0 granted.
- refill_valid and store_valid held continuously → refill wins 8 cycles. Cycle 9: store_ready=1, refill_ready=0, starve_cnt=0. Cycle 10: refill wins again.
